// File: rtl/frame_stream_mux.sv
// Frame-aware stream selector with synchronised select/shift and pixel windowing.
// Optional statistics counters enabled by FRAME_STREAM_MUX_STATS_EN.
module frame_stream_mux #(
  parameter int N_CH    = 3,
  parameter int SEL_W   = 2,
  parameter int DATA_W  = 10,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SEL_W-1:0]         sel,
  input  logic [SHIFT_W-1:0]       shift,
  input  logic [N_CH-1:0]          in_valid,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [N_CH-1:0]          in_sop,
  input  logic [N_CH-1:0]          in_eop,
  output logic                     out_valid,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic [OUT_W-1:0]         out_data,
  output logic [SEL_W-1:0]         active_ch,
  output logic                     in_frame,
  output logic [15:0]              frame_cnt,
  output logic [15:0]              err_cnt
);

  localparam int MAX_S = DATA_W - OUT_W;
  localparam logic [SHIFT_W-1:0] MAX_S_W = SHIFT_W'(MAX_S);

  typedef enum logic {IDLE, IN_FRAME} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_m_q, sel_s_q;
  logic [SHIFT_W-1:0] shift_m_q, shift_s_q;
  logic [SEL_W-1:0]   active_ch_q, active_ch_d;
  logic [SHIFT_W-1:0] shift_lat_q, shift_lat_d;
  logic               out_valid_q, out_valid_d;
  logic               out_sop_q, out_sop_d;
  logic               out_eop_q, out_eop_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;

  logic [SEL_W-1:0]   req_ch, cur_ch;
  logic [SHIFT_W-1:0] cur_shift, s_eff;
  logic               beat_v, beat_sop, beat_eop;
  logic [DATA_W-1:0]  pix, shifted;
  logic [OUT_W-1:0]   pix_out;

  // Out-of-range selects fall back to channel 0
  assign req_ch    = (int'(sel_s_q) >= N_CH) ? '0 : sel_s_q;
  assign cur_ch    = (state_q == IDLE) ? req_ch : active_ch_q;
  assign cur_shift = (state_q == IDLE) ? shift_s_q : shift_lat_q;

  assign beat_v   = in_valid[cur_ch];
  assign beat_sop = in_sop[cur_ch];
  assign beat_eop = in_eop[cur_ch];
  assign pix      = in_data[cur_ch*DATA_W +: DATA_W];

  assign s_eff   = (cur_shift > MAX_S_W) ? MAX_S_W : cur_shift;
  assign shifted = pix >> s_eff;
  assign pix_out = (|(shifted >> OUT_W)) ? '1 : shifted[OUT_W-1:0];

  always_comb begin
    state_d     = state_q;
    active_ch_d = active_ch_q;
    shift_lat_d = shift_lat_q;
    out_valid_d = 1'b0;
    out_sop_d   = 1'b0;
    out_eop_d   = 1'b0;
    out_data_d  = out_data_q;
    if (beat_v) begin
      unique case (state_q)
        IDLE: begin
          if (beat_sop) begin
            out_valid_d = 1'b1;
            out_sop_d   = 1'b1;
            out_eop_d   = beat_eop;
            out_data_d  = pix_out;
            active_ch_d = req_ch;
            shift_lat_d = shift_s_q;
            if (!beat_eop) state_d = IN_FRAME;
          end
        end
        IN_FRAME: begin
          out_valid_d = 1'b1;
          out_sop_d   = beat_sop;
          out_eop_d   = beat_eop;
          out_data_d  = pix_out;
          if (beat_eop) state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_m_q     <= '0;
      sel_s_q     <= '0;
      shift_m_q   <= '0;
      shift_s_q   <= '0;
      active_ch_q <= '0;
      shift_lat_q <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_m_q     <= sel;
      sel_s_q     <= sel_m_q;
      shift_m_q   <= shift;
      shift_s_q   <= shift_m_q;
      active_ch_q <= active_ch_d;
      shift_lat_q <= shift_lat_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_data  = out_data_q;
  assign active_ch = active_ch_q;
  assign in_frame  = (state_q == IN_FRAME);

`ifdef FRAME_STREAM_MUX_STATS_EN
  logic        frame_inc, err_inc;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Errors: headless beat in IDLE, or a restart sop inside a frame
  assign frame_inc = out_valid_d && beat_eop;
  assign err_inc   = beat_v &&
                     ((state_q == IDLE) ? !beat_sop : beat_sop);

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (frame_inc && frame_cnt_q != 16'hFFFF)
      frame_cnt_d = frame_cnt_q + 16'd1;
    if (err_inc && err_cnt_q != 16'hFFFF)
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`else
  assign frame_cnt = '0;
  assign err_cnt   = '0;
`endif

endmodule
